// File: rtl/systolic_output_deskew_pkg.sv
// Shared constants for the systolic output deskew path.
// Column-count width, default result width and the column clamp helper.
package systolic_output_deskew_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int COL_W      = 16;
    localparam int SLICE_W    = DATA_W_DEF;

    // Clamp a requested column count to the physical array width.
    function automatic logic [COL_W-1:0] clamp_cols(
        input logic [COL_W-1:0] req,
        input int unsigned      lim
    );
        if (32'(req) > lim)
            return COL_W'(lim);
        return req;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head shows the oldest entry, holds when empty.
// Ports: clk, rst (async active-low), push/push_data, pop, head, full, empty.
module sync_fifo #(
    parameter int WIDTH_BITS = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH_BITS-1:0] push_data,
    input  logic                  pop,
    output logic [WIDTH_BITS-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH_BITS-1:0] mem [DEPTH];
    logic [WIDTH_BITS-1:0] last_q;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);

    // Last popped head is shown while empty so the output never jumps to stale slots.
    assign head = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns staggered systolic output rows and queues them for the unified buffer.
// Ports: sys_data/valid in, col size load, row out handshake, sticky errors, row count.
module systolic_output_deskew
    import systolic_output_deskew_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0][DATA_W-1:0]   sys_data_in,
    input  logic [WIDTH-1:0]               sys_valid_in,
    input  logic [COL_W-1:0]               ub_rd_col_size_in,
    input  logic                           ub_rd_col_size_valid_in,
    output logic [WIDTH*DATA_W-1:0]        row_data_out,
    output logic                           row_valid_out,
    input  logic                           row_ready_in,
    output logic                           overflow_out,
    output logic                           align_err_out,
    input  logic                           err_clr_in,
    output logic [COL_W-1:0]               row_cnt_out
);

    logic [WIDTH-1:0]             al_v;
    logic [WIDTH-1:0][DATA_W-1:0] al_d;
    logic [WIDTH-1:0]             act;
    logic [COL_W-1:0]             col_cnt;
    logic [WIDTH*DATA_W-1:0]      wdata;
    logic                         push;
    logic                         aerr_set;
    logic                         ovf_set;
    logic                         pop;
    logic                         push_ok;
    logic                         full;
    logic                         empty;

    // Column c is delayed WIDTH-1-c cycles so every column lines up with the last.
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        if (c == WIDTH-1) begin : g_comb
            assign al_v[c] = sys_valid_in[c];
            assign al_d[c] = sys_data_in[c];
        end else begin : g_dly
            localparam int N = WIDTH-1-c;
            logic [N-1:0]             v_q;
            logic [N-1:0][DATA_W-1:0] d_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q[0] <= sys_valid_in[c];
                    d_q[0] <= sys_data_in[c];
                    for (int k = 1; k < N; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
            assign al_v[c] = v_q[N-1];
            assign al_d[c] = d_q[N-1];
        end
    end

    always_comb begin
        act   = '0;
        wdata = '0;
        for (int c = 0; c < WIDTH; c++) begin
            act[c] = (COL_W'(c) < col_cnt);
            if (act[c])
                wdata[c*DATA_W +: DATA_W] = al_d[c];
        end
        push = al_v[0];
        // A stray active-column valid without column 0 is flagged but not written.
        aerr_set = al_v[0] ? |(act & ~al_v) : |(act & al_v);
    end

    assign pop     = row_valid_out & row_ready_in;
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    sync_fifo #(
        .WIDTH_BITS (WIDTH*DATA_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wdata),
        .pop       (pop),
        .head      (row_data_out),
        .full      (full),
        .empty     (empty)
    );

    assign row_valid_out = ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt       <= COL_W'(WIDTH);
            row_cnt_out   <= '0;
            overflow_out  <= 1'b0;
            align_err_out <= 1'b0;
        end else begin
            if (ub_rd_col_size_valid_in && ub_rd_col_size_in != '0)
                col_cnt <= clamp_cols(ub_rd_col_size_in, WIDTH);
            if (push_ok)
                row_cnt_out <= row_cnt_out + 1'b1;
            if (ovf_set)
                overflow_out <= 1'b1;
            else if (err_clr_in)
                overflow_out <= 1'b0;
            if (aerr_set)
                align_err_out <= 1'b1;
            else if (err_clr_in)
                align_err_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew at WIDTH=2, DEPTH=4.
// Drives and samples on the falling edge; expectations are hand-computed.
module tb_systolic_output_deskew;

    localparam int WIDTH  = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [WIDTH-1:0][DATA_W-1:0] sys_data = '0;
    logic [WIDTH-1:0]             sys_valid = '0;
    logic [15:0]                  col_size = '0;
    logic                         col_size_vld = 1'b0;
    logic [WIDTH*DATA_W-1:0]      row_data;
    logic                         row_valid;
    logic                         row_ready = 1'b0;
    logic                         ovf;
    logic                         aerr;
    logic                         err_clr = 1'b0;
    logic [15:0]                  row_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_output_deskew #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .sys_data_in             (sys_data),
        .sys_valid_in            (sys_valid),
        .ub_rd_col_size_in       (col_size),
        .ub_rd_col_size_valid_in (col_size_vld),
        .row_data_out            (row_data),
        .row_valid_out           (row_valid),
        .row_ready_in            (row_ready),
        .overflow_out            (ovf),
        .align_err_out           (aerr),
        .err_clr_in              (err_clr),
        .row_cnt_out             (row_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        sys_valid = '0;
        sys_data  = '0;
    endtask

    task automatic load_cols(input logic [15:0] n);
        col_size     = n;
        col_size_vld = 1'b1;
        step();
        col_size_vld = 1'b0;
    endtask

    initial begin
        step();
        chk("rst_valid", 64'(row_valid), 64'd0);
        chk("rst_data", row_data, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_aerr", 64'(aerr), 64'd0);
        chk("rst_cnt", 64'(row_cnt), 64'd0);
        rst = 1'b1;
        row_ready = 1'b1;
        step();

        // Full-width row: col0=10 at E0, col1=20 at E1.
        sys_data[0] = 32'd10; sys_valid[0] = 1'b1;
        step();
        idle();
        sys_data[1] = 32'd20; sys_valid[1] = 1'b1;
        step();
        idle();
        chk("r1_valid", 64'(row_valid), 64'd1);
        chk("r1_data", row_data, {32'd20, 32'd10});
        chk("r1_cnt", 64'(row_cnt), 64'd1);
        chk("r1_aerr", 64'(aerr), 64'd0);
        step();
        chk("r1_popped", 64'(row_valid), 64'd0);
        chk("r1_hold", row_data, {32'd20, 32'd10});

        // Single active column; size 0 is ignored afterwards.
        load_cols(16'd1);
        load_cols(16'd0);
        sys_data[0] = 32'd7; sys_valid[0] = 1'b1;
        sys_data[1] = 32'h99;
        step();
        idle();
        step();
        chk("r2_valid", 64'(row_valid), 64'd1);
        chk("r2_data", row_data, {32'd0, 32'd7});
        chk("r2_aerr", 64'(aerr), 64'd0);
        chk("r2_cnt", 64'(row_cnt), 64'd2);
        step();

        // Overflow: 5 back-to-back rows into a 4-deep FIFO.
        row_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sys_data[0] = 32'(i); sys_valid[0] = 1'b1;
            step();
        end
        idle();
        step();
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_cnt", 64'(row_cnt), 64'd6);
        row_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", 64'(row_valid), 64'd1);
            chk("drain_data", row_data, 64'(k));
            step();
        end
        chk("drain_empty", 64'(row_valid), 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);

        // Full FIFO with a pop in the same cycle as a new push.
        row_ready = 1'b0;
        for (int i = 11; i <= 15; i++) begin
            sys_data[0] = 32'(i); sys_valid[0] = 1'b1;
            step();
        end
        idle();
        row_ready = 1'b1;
        step();
        chk("fp_ovf", 64'(ovf), 64'd0);
        chk("fp_cnt", 64'(row_cnt), 64'd11);
        for (int k = 12; k <= 15; k++) begin
            chk("fp_valid", 64'(row_valid), 64'd1);
            chk("fp_data", row_data, 64'(k));
            step();
        end
        chk("fp_empty", 64'(row_valid), 64'd0);
        chk("fp_aerr", 64'(aerr), 64'd0);

        // Oversized column request clamps to WIDTH.
        load_cols(16'd5);
        sys_data[0] = 32'd30; sys_valid[0] = 1'b1;
        step();
        idle();
        sys_data[1] = 32'd40; sys_valid[1] = 1'b1;
        step();
        idle();
        chk("clamp_data", row_data, {32'd40, 32'd30});
        chk("clamp_aerr", 64'(aerr), 64'd0);
        step();

        // Column 1 valid without column 0.
        sys_data[1] = 32'd55; sys_valid[1] = 1'b1;
        step();
        idle();
        chk("ae_flag", 64'(aerr), 64'd1);
        chk("ae_nopush", 64'(row_valid), 64'd0);
        chk("ae_cnt", 64'(row_cnt), 64'd12);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ae_clr", 64'(aerr), 64'd0);

        // Reset while a row is half-way through the skew.
        sys_data[0] = 32'd50; sys_valid[0] = 1'b1;
        step();
        idle();
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_data", row_data, 64'd0);
        chk("mid_rst_cnt", 64'(row_cnt), 64'd0);
        chk("mid_rst_valid", 64'(row_valid), 64'd0);
        sys_data[1] = 32'd60; sys_valid[1] = 1'b1;
        step();
        idle();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_valid", 64'(row_valid), 64'd0);
        end
        chk("post_rst_cnt", 64'(row_cnt), 64'd0);
        chk("post_rst_aerr", 64'(aerr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
